systolic_feed_ctrl: RTL and testbench

Sequencer for the 4x4 systolic array's operand memories. It owns the shared control bus (enable, write-enable, address, write data) of the N_RAM pre-skewed 16x16-bit operand RAMs that feed the array's row and column edges. It arbitrates between host loading and compute streaming, and runs the compute sequence: clear, feed, drain, done. It sits between the top-level host interface and the RAM/PE-array datapath.

---
 rtl/systolic_feed_ctrl_pkg.sv | 19 +
 rtl/systolic_host_wr_port.sv | 48 ++++
 rtl/systolic_feed_ctrl.sv | 136 +++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types and default geometry for the systolic operand-feed sequencer.
// Drain length follows the array size: 2N-1 cycles to flush an NxN skewed array.
package systolic_feed_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int ARRAY_N       = 4;
  localparam int LEN_DEF       = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int DRAIN_CYC_DEF = 2 * ARRAY_N - 1;

endpackage

// File: rtl/systolic_host_wr_port.sv
// Registered host write decoder: one-hot RAM select plus address/data, one cycle latency.
// Out-of-range selects decode to no enable, so the write is silently dropped.
module systolic_host_wr_port
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_RAM  = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [N_RAM-1:0]  wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [N_RAM-1:0] dec;

  always_comb begin
    dec = '0;
    for (int i = 0; i < N_RAM; i++) begin
      dec[i] = (sel == SEL_W'(i));
    end
  end

  // Address/data idle at zero so the top can OR them with the feed address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (accept) begin
      wr_en   <= dec;
      wr_addr <= addr;
      wr_data <= data;
    end else begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Operand RAM sequencer for the systolic array: host loading in IDLE, then clear/feed/drain/done.
// Outputs are registered from next-state; host writes land one cycle after acceptance.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LEN       = LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_RAM     = 8,
  parameter int SEL_W     = 3,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              host_wr,
  input  logic [SEL_W-1:0]  host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic [N_RAM-1:0]  ram_en,
  output logic [N_RAM-1:0]  ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              pe_clear,
  output logic              pe_valid,
  output logic              busy,
  output logic              done
);

  localparam int                DRN_W      = $clog2(DRAIN_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LEN - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(DRAIN_CYC - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DRN_W-1:0]  drain_q, drain_nx;
  logic              feed_q;
  logic              clear_nx, feed_nx, busy_nx, done_nx;
  logic              host_acc;
  logic [N_RAM-1:0]  hw_en;
  logic [ADDR_W-1:0] hw_addr;
  logic [DATA_W-1:0] hw_data;

  assign host_ready = (state == S_IDLE);
  assign host_acc   = host_wr & host_ready;

  systolic_host_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_RAM  (N_RAM),
    .SEL_W  (SEL_W)
  ) u_host_wr (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (host_acc),
    .sel     (host_sel),
    .addr    (host_addr),
    .data    (host_data),
    .wr_en   (hw_en),
    .wr_addr (hw_addr),
    .wr_data (hw_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    drain_nx = drain_q;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        state_nx = S_FEED;
        addr_nx  = '0;
      end
      S_FEED: begin
        if (addr_q == LAST_ADDR) begin
          state_nx = S_DRAIN;
          drain_nx = DRAIN_LOAD;
        end else begin
          addr_nx = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_nx = S_DONE;
        end else begin
          drain_nx = drain_q - DRN_W'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    clear_nx = (state_nx == S_CLEAR);
    feed_nx  = (state_nx == S_FEED);
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state_nx == S_DONE);
  end

  // Feed address is held at zero outside FEED so it can share the bus with host writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      drain_q  <= '0;
      feed_q   <= 1'b0;
      pe_clear <= 1'b0;
      pe_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      addr_q   <= feed_nx ? addr_nx : '0;
      drain_q  <= drain_nx;
      feed_q   <= feed_nx;
      pe_clear <= clear_nx;
      pe_valid <= feed_q;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Host strobes only occur in IDLE/CLEAR and feed only in FEED, so these ORs never collide.
  assign ram_en   = hw_en | {N_RAM{feed_q}};
  assign ram_we   = hw_en;
  assign ram_addr = hw_addr | addr_q;
  assign ram_di   = hw_data;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: host write table, run timing, mid-run ignores and reset abort.
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, host_wr;
  logic [2:0]  host_sel;
  logic [3:0]  host_addr;
  logic [15:0] host_data;

  logic        host_ready, pe_clear, pe_valid, busy, done;
  logic [7:0]  ram_en, ram_we;
  logic [3:0]  ram_addr;
  logic [15:0] ram_di;

  logic        ready6, clear6, valid6, busy6, done6;
  logic [5:0]  en6, we6;
  logic [3:0]  addr6;
  logic [15:0] di6;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0]  en;
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic [2:0]  sel;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [7:0]  exp_en8;
    logic [5:0]  exp_en6;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  systolic_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .host_wr(host_wr),
    .host_sel(host_sel), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_di(ram_di), .pe_clear(pe_clear),
    .pe_valid(pe_valid), .busy(busy), .done(done)
  );

  systolic_feed_ctrl #(.N_RAM(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .host_wr(host_wr),
    .host_sel(host_sel), .host_addr(host_addr), .host_data(host_data),
    .host_ready(ready6), .ram_en(en6), .ram_we(we6),
    .ram_addr(addr6), .ram_di(di6), .pe_clear(clear6),
    .pe_valid(valid6), .busy(busy6), .done(done6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-strobe scoreboard: every accepted write must appear exactly once, in order.
  always @(posedge clk) begin
    #1;
    if (ram_we != 8'h00) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(ram_we), 32'h0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_en",   32'(ram_en),   32'(e.en));
        check("wr_we",   32'(ram_we),   32'(e.en));
        check("wr_addr", 32'(ram_addr), 32'(e.addr));
        check("wr_data", 32'(ram_di),   32'(e.data));
      end
    end
  end

  // Call in IDLE with #1 past an edge; cycle 1 is the cycle after start is sampled.
  task automatic run_seq(input bit with_wr, input bit inj_mid);
    logic [16:0] exp_v, act_v;
    logic [7:0]  c1_en;
    logic [3:0]  c1_addr;
    c1_en   = with_wr ? 8'h80 : 8'h00;
    c1_addr = with_wr ? 4'd15 : 4'd0;
    start = 1'b1;
    if (with_wr) begin
      host_wr = 1'b1; host_sel = 3'd7; host_addr = 4'd15; host_data = 16'hABCD;
      sb.push_back('{en: 8'h80, addr: 4'd15, data: 16'hABCD});
    end
    step();
    start = 1'b0;
    host_wr = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      bit feed;
      feed = (c >= 2) && (c <= 17);
      exp_v = {(c == 1), (c >= 3 && c <= 18), (c >= 1 && c <= 25), (c == 25),
               !(c >= 1 && c <= 25),
               feed ? 8'hFF : ((c == 1) ? c1_en : 8'h00),
               feed ? 4'(c - 2) : ((c == 1) ? c1_addr : 4'd0)};
      act_v = {pe_clear, pe_valid, busy, done, host_ready, ram_en, ram_addr};
      check($sformatf("run_c%0d", c), 32'(act_v), 32'(exp_v));
      if (inj_mid && c == 5) begin
        host_wr = 1'b1; host_sel = 3'd1; host_addr = 4'd3; host_data = 16'h0055;
        start = 1'b1;
      end else begin
        host_wr = 1'b0;
        start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    tbl[0] = '{sel: 3'd2, addr: 4'd9,  data: 16'h0001, exp_en8: 8'h04, exp_en6: 6'h04};
    tbl[1] = '{sel: 3'd0, addr: 4'd0,  data: 16'hFFFF, exp_en8: 8'h01, exp_en6: 6'h01};
    tbl[2] = '{sel: 3'd7, addr: 4'd15, data: 16'hABCD, exp_en8: 8'h80, exp_en6: 6'h00};
    tbl[3] = '{sel: 3'd5, addr: 4'd3,  data: 16'h1234, exp_en8: 8'h20, exp_en6: 6'h20};
    tbl[4] = '{sel: 3'd6, addr: 4'd7,  data: 16'h5A5A, exp_en8: 8'h40, exp_en6: 6'h00};
    tbl[5] = '{sel: 3'd1, addr: 4'd1,  data: 16'h0F0F, exp_en8: 8'h02, exp_en6: 6'h02};

    rst_n = 1'b0; start = 1'b0; host_wr = 1'b0;
    host_sel = '0; host_addr = '0; host_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("reset_outs", 32'({ram_en, ram_we, ram_addr, pe_clear, pe_valid, busy, done}), 32'h0);
    check("reset_di", 32'(ram_di), 32'h0);
    check("reset_ready", 32'(host_ready), 32'h1);
    check("reset6", 32'({en6, we6, addr6, clear6, valid6, busy6, done6, ready6}), 32'h1);
    check("reset6_di", 32'(di6), 32'h0);

    // Back-to-back host writes; the 6-RAM instance must drop selects 6 and 7.
    for (int i = 0; i < 6; i++) begin
      host_wr = 1'b1; host_sel = tbl[i].sel;
      host_addr = tbl[i].addr; host_data = tbl[i].data;
      sb.push_back('{en: tbl[i].exp_en8, addr: tbl[i].addr, data: tbl[i].data});
      step();
      check($sformatf("en6_v%0d", i), 32'(en6), 32'(tbl[i].exp_en6));
      check($sformatf("we6_v%0d", i), 32'(we6), 32'(tbl[i].exp_en6));
      check($sformatf("ready6_v%0d", i), 32'(ready6), 32'h1);
    end
    host_wr = 1'b0;
    step();
    check("sb_after_table", 32'(sb.size()), 32'h0);

    run_seq(1'b0, 1'b0);
    run_seq(1'b0, 1'b1);
    run_seq(1'b1, 1'b0);

    // Reset in the middle of FEED abandons the run without a done pulse.
    begin
      bit seen_done;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 10; c++) step();
      check("mid_feed_busy", 32'({busy, ram_en}), 32'h1FF);
      rst_n = 1'b0;
      step();
      check("abort_outs", 32'({ram_en, ram_we, ram_addr, pe_clear, pe_valid, busy, done}), 32'h0);
      check("abort_di", 32'(ram_di), 32'h0);
      check("abort_ready", 32'(host_ready), 32'h1);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
        seen_done |= done;
        step();
      end
      check("abort_no_done", 32'(seen_done), 32'h0);
    end
    run_seq(1'b0, 1'b0);

    repeat (2) step();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
